// File: rtl/ring_token_arbiter.sv
// Local owner of this core's ring token: captures an arriving Token, hands it to
// local requesters in round-robin order, and puts it back on the ring afterwards.
module ring_token_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 2,
    parameter int MAXHOLD  = 255,
    parameter int CNTW     = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      whichCore,
    input  logic [3:0]      SlotTypeIn,
    input  logic [NREQ-1:0] want,
    input  logic [NREQ-1:0] drive,
    output logic [NREQ-1:0] acquire,
    output logic            arbDriveRing,
    output logic [3:0]      arbSlotTypeOut,
    output logic [3:0]      arbSourceOut,
    output logic [31:0]     arbRingOut,
    output logic            busy,
    output logic [2:0]      grantIdx,
    output logic            holdErr
);
    localparam logic [1:0] PASS    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [3:0] TOKEN   = 4'd1;

    localparam int BW = $clog2(MAXBURST + 2);
    localparam int HW = CNTW + 1;
    localparam logic [BW-1:0]   BURSTLIM = BW'(MAXBURST);
    localparam logic [BW-1:0]   BURSTONE = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [CNTW:0]   HOLDLIM  = HW'(MAXHOLD);
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      state;
    logic [2:0]      rrPtr;
    logic [BW-1:0]   burstCnt;
    logic [CNTW-1:0] holdCnt;
    logic [NREQ-1:0] reqMask;
    logic [3:0]      winner;
    logic [2:0]      ptrNext;
    logic [CNTW:0]   holdNext;
    logic            tokenIn;
    logic            granteeDrive;
    logic            holdExpire;
    logic            doGrant;
    logic            doRelease;

    // First requester at or after ptr, wrapping; result is {found, index}.
    function automatic logic [3:0] pickWinner(input logic [NREQ-1:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [3:0] idx;
        res = 4'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (|(req & (ONE << idx))) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    // Arbitration decision for the current cycle.
    always_comb begin
        tokenIn      = (SlotTypeIn == TOKEN);
        granteeDrive = |(drive & (ONE << grantIdx));
        holdNext     = {1'b0, holdCnt} + {{CNTW{1'b0}}, 1'b1};
        holdExpire   = granteeDrive && (holdNext >= HOLDLIM);
        // The current grantee's own want is stale during HOLD and must not win.
        if (state == HOLD) begin
            reqMask = want & ~(ONE << grantIdx);
        end else begin
            reqMask = want;
        end
        winner = pickWinner(reqMask, rrPtr);
        if (winner[2:0] == 3'(NREQ - 1)) begin
            ptrNext = 3'd0;
        end else begin
            ptrNext = winner[2:0] + 3'd1;
        end
        doGrant   = 1'b0;
        doRelease = 1'b0;
        case (state)
            PASS: begin
                doGrant = tokenIn && winner[3];
            end
            HOLD: begin
                if (granteeDrive) begin
                    doGrant = 1'b0;
                end else if (winner[3] && (burstCnt < BURSTLIM)) begin
                    doGrant = 1'b1;
                end else begin
                    doRelease = 1'b1;
                end
            end
            RELEASE: begin
                doRelease = 1'b1;
            end
            default: begin
                doGrant   = 1'b0;
                doRelease = 1'b0;
            end
        endcase
    end

    // Ring-facing outputs; grant and emit pulses are suppressed while in reset.
    always_comb begin
        if (reset) begin
            acquire      = {NREQ{1'b0}};
            arbDriveRing = 1'b0;
        end else begin
            acquire      = doGrant ? (ONE << winner[2:0]) : {NREQ{1'b0}};
            arbDriveRing = doRelease;
        end
        arbSlotTypeOut = TOKEN;
        arbSourceOut   = whichCore;
        arbRingOut     = 32'd0;
        busy           = (state != PASS);
    end

    // Token ownership state, round-robin pointer, burst and hold accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PASS;
            rrPtr    <= 3'd0;
            grantIdx <= 3'd0;
            burstCnt <= {BW{1'b0}};
            holdCnt  <= {CNTW{1'b0}};
            holdErr  <= 1'b0;
        end else begin
            case (state)
                PASS: begin
                    if (doGrant) begin
                        state    <= HOLD;
                        grantIdx <= winner[2:0];
                        rrPtr    <= ptrNext;
                        burstCnt <= BURSTONE;
                        holdCnt  <= {CNTW{1'b0}};
                    end
                end
                HOLD: begin
                    if (holdExpire) begin
                        holdCnt <= holdNext[CNTW-1:0];
                        holdErr <= 1'b1;
                        state   <= RELEASE;
                    end else if (granteeDrive) begin
                        holdCnt <= holdNext[CNTW-1:0];
                    end else if (doGrant) begin
                        grantIdx <= winner[2:0];
                        rrPtr    <= ptrNext;
                        burstCnt <= burstCnt + BURSTONE;
                        holdCnt  <= {CNTW{1'b0}};
                    end else begin
                        state <= PASS;
                    end
                end
                RELEASE: begin
                    state <= PASS;
                end
                default: begin
                    state <= PASS;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ring_token_arbiter.sv
// Randomized scoreboard bench for ring_token_arbiter: a token-ownership model
// predicts every grant/emit pulse, and a negedge monitor compares DUT pulses.
module tb_ring_token_arbiter;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 2;
    localparam int MAXHOLD  = 4;
    localparam int CNTW     = 8;
    localparam logic [3:0] CORE = 4'd5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  whichCore = CORE;
    logic [3:0]  SlotTypeIn = 4'd7;
    logic [3:0]  want = 4'd0;
    logic [3:0]  drive = 4'd0;
    logic [3:0]  acquire;
    logic        arbDriveRing;
    logic [3:0]  arbSlotTypeOut;
    logic [3:0]  arbSourceOut;
    logic [31:0] arbRingOut;
    logic        busy;
    logic [2:0]  grantIdx;
    logic        holdErr;

    ring_token_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST), .MAXHOLD(MAXHOLD), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset), .whichCore(whichCore), .SlotTypeIn(SlotTypeIn),
        .want(want), .drive(drive), .acquire(acquire), .arbDriveRing(arbDriveRing),
        .arbSlotTypeOut(arbSlotTypeOut), .arbSourceOut(arbSourceOut), .arbRingOut(arbRingOut),
        .busy(busy), .grantIdx(grantIdx), .holdErr(holdErr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  acq;
        logic        rel;
        logic        busy;
        logic [2:0]  gidx;
        logic        err;
    } ev_t;

    ev_t expQ[$];
    ev_t monAct;
    ev_t monExp;
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;

    // Reference model: who owns the token, whether it is being forced back, counters.
    bit         mHeld;
    bit         mForced;
    bit         mErr;
    int         mOwner;
    int         mPtr;
    int         mBurst;
    int         mCnt;
    logic [3:0] wantR;
    logic [3:0] lastAcq;
    int         remain[NREQ];
    int         lenCfg[NREQ];

    function automatic int rrPick(input logic [3:0] req, input int from);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (from + k) % NREQ;
            if (((req >> j) & 4'd1) != 4'd0) return j;
        end
        return -1;
    endfunction

    task automatic resetModel();
        mHeld = 1'b0; mForced = 1'b0; mErr = 1'b0;
        mOwner = 0; mPtr = 0; mBurst = 0; mCnt = 0;
        wantR = 4'd0; lastAcq = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            remain[i] = 0;
            lenCfg[i] = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One ring cycle: drive requester inputs, predict the arbiter's pulse, advance requesters.
    task automatic step(input bit tok);
        logic [3:0] dv;
        logic [3:0] others;
        int         g;
        ev_t        e;
        @(posedge clock);
        #1;
        cyc++;
        dv = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (remain[i] > 0) dv = dv | (4'd1 << i);
        end
        want  = wantR;
        drive = dv;
        SlotTypeIn = tok ? 4'd1 : (($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8);
        e      = '0;
        e.cyc  = 32'(cyc);
        e.busy = mHeld || mForced;
        e.gidx = 3'(mOwner);
        e.err  = mErr;
        g = -1;
        if (mForced) begin
            e.rel = 1'b1;
            mForced = 1'b0;
        end else if (!mHeld) begin
            if (tok && wantR != 4'd0) begin
                g = rrPick(wantR, mPtr);
                mBurst = 1;
                mHeld = 1'b1;
            end
        end else if (((dv >> mOwner) & 4'd1) != 4'd0) begin
            mCnt++;
            if (mCnt >= MAXHOLD) begin
                mErr = 1'b1;
                mHeld = 1'b0;
                mForced = 1'b1;
            end
        end else begin
            others = wantR & ~(4'd1 << mOwner);
            if (others != 4'd0 && mBurst < MAXBURST) begin
                g = rrPick(others, mPtr);
                mBurst++;
            end else begin
                e.rel = 1'b1;
                mHeld = 1'b0;
            end
        end
        if (g >= 0) begin
            e.acq = 4'd1 << g;
            mOwner = g;
            mPtr = (g + 1) % NREQ;
            mCnt = 0;
        end
        lastAcq = e.acq;
        if (e.acq != 4'd0 || e.rel) expQ.push_back(e);
        for (int i = 0; i < NREQ; i++) begin
            if (remain[i] > 0) remain[i]--;
        end
        if (g >= 0) begin
            wantR = wantR & ~(4'd1 << g);
            remain[g] = lenCfg[g] - 1;
        end
    endtask

    // Monitor: every DUT pulse must match the head of the expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (acquire != 4'd0 || arbDriveRing) begin
                monAct = {32'(cyc), acquire, arbDriveRing, busy, grantIdx, holdErr};
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_pulse: cyc=%0d acquire=%b arbDriveRing=%b, required no pulse",
                             cyc, acquire, arbDriveRing);
                end else begin
                    monExp = expQ.pop_front();
                    if (monAct !== monExp) begin
                        mismatched++;
                        $display("FAIL pulse: got cyc=%0d acq=%b rel=%b busy=%b gidx=%0d err=%b, required cyc=%0d acq=%b rel=%b busy=%b gidx=%0d err=%b",
                                 monAct.cyc, monAct.acq, monAct.rel, monAct.busy, monAct.gidx, monAct.err,
                                 monExp.cyc, monExp.acq, monExp.rel, monExp.busy, monExp.gidx, monExp.err);
                    end
                    if (arbDriveRing) begin
                        compared++;
                        if ({arbSlotTypeOut, arbSourceOut, arbRingOut} !== {4'd1, CORE, 32'd0}) begin
                            mismatched++;
                            $display("FAIL token_fields: got type=%0d src=%0d data=%0h, required type=1 src=%0d data=0",
                                     arbSlotTypeOut, arbSourceOut, arbRingOut, CORE);
                        end
                    end
                end
            end else if (expQ.size() > 0 && expQ[0].cyc == 32'(cyc)) begin
                compared++;
                mismatched++;
                monExp = expQ.pop_front();
                $display("FAIL missing_pulse: cyc=%0d got no pulse, required acq=%b rel=%b", cyc, monExp.acq, monExp.rel);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, compared=%0d", compared);
        $fatal(1);
    end

    initial begin
        resetModel();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_acquire", 32'(acquire), 32'd0);
        chk("reset_drive_ring", 32'(arbDriveRing), 32'd0);
        chk("reset_grantIdx", 32'(grantIdx), 32'd0);
        chk("reset_holdErr", 32'(holdErr), 32'd0);
        reset = 1'b0;

        // Token with nobody asking passes straight through.
        step(1'b1);
        #1;
        chk("idle_token_acquire", 32'(acquire), 32'd0);
        chk("idle_token_drive", 32'(arbDriveRing), 32'd0);
        chk("idle_token_busy", 32'(busy), 32'd0);

        // Burst: 0 then 1 by handoff, then 3 then 0 with pointer wrap.
        lenCfg[0] = 1; lenCfg[1] = 1; lenCfg[3] = 1;
        wantR = 4'b1011;
        step(1'b1);
        repeat (3) step(1'b0);
        wantR = wantR | 4'b0001;
        step(1'b1);
        repeat (3) step(1'b0);

        // Messenger header plus three payload words.
        lenCfg[0] = 4;
        wantR = 4'b0001;
        step(1'b1);
        #1;
        chk("messenger_acquire", 32'(acquire), 32'b0001);
        repeat (5) step(1'b0);

        // Illegal Token in the cycle the grantee stops driving.
        lenCfg[3] = 3;
        wantR = 4'b1000;
        step(1'b1);
        repeat (2) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b0);

        // Grantee overstays the hold limit.
        lenCfg[0] = 11;
        wantR = 4'b0001;
        step(1'b1);
        repeat (12) step(1'b0);
        chk("holdErr_set", 32'(holdErr), 32'd1);
        lenCfg[1] = 2;
        wantR = 4'b0010;
        step(1'b1);
        repeat (3) step(1'b0);
        chk("holdErr_sticky", 32'(holdErr), 32'd1);

        // Asynchronous reset during a handoff pulse.
        lenCfg[0] = 1; lenCfg[1] = 1;
        wantR = 4'b0011;
        step(1'b1);
        step(1'b0);
        #1;
        chk("handoff_before_reset", 32'(acquire), 32'(lastAcq));
        reset = 1'b1;
        expQ.delete();
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_acquire", 32'(acquire), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        want = 4'd0; drive = 4'd0; SlotTypeIn = 4'd7;
        resetModel();
        chk("holdErr_cleared", 32'(holdErr), 32'd0);
        lenCfg[2] = 1;
        wantR = 4'b0100;
        step(1'b1);
        #1;
        chk("post_reset_grant", 32'(acquire), 32'b0100);
        repeat (2) step(1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((wantR >> i) & 4'd1) == 4'd0 && remain[i] == 0 &&
                    !((mHeld || mForced) && mOwner == i) && $urandom_range(0, 3) == 0) begin
                    wantR = wantR | (4'd1 << i);
                    lenCfg[i] = $urandom_range(1, 6);
                end
            end
            step($urandom_range(0, 2) == 0);
        end

        wantR = 4'd0;
        for (int k = 0; k < 30 && (mHeld || mForced); k++) step(1'b0);
        repeat (2) step(1'b0);
        #1;
        chk("final_busy", 32'(busy), 32'd0);
        chk("queue_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
